sram_async_ctrl: RTL

Parametrised controller for asynchronous SRAM (CY7C1399B class and wider/deeper parts); next generation of the CY7C1399B_interface.
- Accepts single or burst read/write requests over a valid/ready handshake.
- Generates active-low CE/OE/WE with programmable wait states and a bus-turnaround gap.
- Sits between fabric logic and the external SRAM pins.

---
 rtl/sram_ctrl_pkg.sv | 24 ++
 rtl/sram_async_ctrl_if.sv | 29 ++
 rtl/sram_beat_timer.sv | 22 ++
 rtl/sram_async_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: state encoding, idle pin levels and wait-timer sizing shared by sram_async_ctrl.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_RD_ACTIVE,
        S_TURN
    } state_t;

    localparam logic CE_N_IDLE = 1'b1;
    localparam logic OE_N_IDLE = 1'b1;
    localparam logic WE_N_IDLE = 1'b1;

    function automatic int cnt_w(input int rd_wait, input int wr_wait, input int turn_cyc);
        int m;
        m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
        m = (turn_cyc > m) ? turn_cyc : m;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sram_async_ctrl_if.sv
// sram_async_ctrl_if: fabric-side request/response bundle of sram_async_ctrl.
interface sram_async_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic              wdata_ack;
    logic              wr_done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_len, req_wdata,
        input  req_ready, wdata_ack, wr_done, rd_data, rd_valid, rd_last, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_wdata,
        output req_ready, wdata_ack, wr_done, rd_data, rd_valid, rd_last, busy
    );
endinterface

// File: rtl/sram_beat_timer.sv
// sram_beat_timer: loadable down counter that parks at zero; times WE pulses, read beats and turnaround.
module sram_beat_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (!o_zero)
            r_cnt <= r_cnt - 1'b1;

    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: async SRAM controller with wait states and read turnaround.
// Bursts (req_len honoured) only when SRAM_BURST_EN is defined; otherwise every request is one beat.
module sram_async_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int RD_WAIT  = 1,
    parameter int WR_WAIT  = 1,
    parameter int TURN_CYC = 1,
    parameter int LEN_W    = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    sram_async_ctrl_if.slave  bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);
    localparam int CNT_W = cnt_w(RD_WAIT, WR_WAIT, TURN_CYC);
    localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_WAIT);
    localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [LEN_W-1:0]  r_beats, w_beats, w_len;
    logic [DATA_W-1:0] r_wdata, w_wdata, r_rd_data;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_accept, w_last, w_sample, w_capture, w_load, w_zero, w_wr;
    logic              r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_ready, r_busy;
    logic              r_wdata_ack, r_wr_done, r_rd_valid, r_rd_last;

`ifdef SRAM_BURST_EN
    assign w_len = bus.req_len;
`else
    assign w_len = bus.req_len & '0;
`endif

    assign w_accept = bus.req_valid && r_ready;
    assign w_last   = r_beats == '0;
    assign w_wr     = w_next inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};

    sram_beat_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_addr     = r_addr;
        w_beats    = r_beats;
        w_wdata    = r_wdata;
        w_sample   = 1'b0;
        w_capture  = 1'b0;
        w_load     = 1'b0;
        w_load_val = RD_LD;
        case (r_state)
            S_IDLE:
                if (w_accept) begin
                    w_addr  = bus.req_addr;
                    w_beats = w_len;
                    w_load  = 1'b1;
                    if (bus.req_we) begin
                        w_next   = S_WR_SETUP;
                        w_wdata  = bus.req_wdata;
                        w_sample = 1'b1;
                    end else begin
                        w_next = S_RD_ACTIVE;
                    end
                end
            S_WR_SETUP: begin
                w_next     = S_WR_PULSE;
                w_load     = 1'b1;
                w_load_val = WR_LD;
            end
            S_WR_PULSE:
                w_next = w_zero ? S_WR_HOLD : S_WR_PULSE;
            S_WR_HOLD:
                if (w_last) begin
                    w_next = S_IDLE;
                end else begin
                    w_next   = S_WR_SETUP;
                    w_addr   = r_addr + 1'b1;
                    w_beats  = r_beats - 1'b1;
                    w_wdata  = bus.req_wdata;
                    w_sample = 1'b1;
                end
            S_RD_ACTIVE:
                if (w_zero) begin
                    w_capture = 1'b1;
                    w_load    = 1'b1;
                    if (w_last) begin
                        w_next     = S_TURN;
                        w_load_val = TURN_LD;
                    end else begin
                        w_addr  = r_addr + 1'b1;
                        w_beats = r_beats - 1'b1;
                    end
                end
            S_TURN:
                w_next = w_zero ? S_IDLE : S_TURN;
            default:
                w_next = S_IDLE;
        endcase
    end

    // Pins are registered from the next state so the SRAM strobes never glitch on state decode.
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_beats     <= '0;
            r_wdata     <= '0;
            r_rd_data   <= '0;
            r_ce_n      <= CE_N_IDLE;
            r_oe_n      <= OE_N_IDLE;
            r_we_n      <= WE_N_IDLE;
            r_dq_oe     <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_wdata_ack <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_addr      <= w_addr;
            r_beats     <= w_beats;
            r_wdata     <= w_wdata;
            r_ce_n      <= (w_wr || w_next == S_RD_ACTIVE) ? 1'b0 : CE_N_IDLE;
            r_oe_n      <= (w_next == S_RD_ACTIVE) ? 1'b0 : OE_N_IDLE;
            r_we_n      <= (w_next == S_WR_PULSE) ? 1'b0 : WE_N_IDLE;
            r_dq_oe     <= w_wr;
            r_ready     <= w_next == S_IDLE;
            r_busy      <= w_next != S_IDLE;
            r_wdata_ack <= w_sample;
            r_wr_done   <= (w_next == S_WR_HOLD) && w_last;
            r_rd_valid  <= w_capture;
            r_rd_last   <= w_capture && w_last;
            if (w_capture)
                r_rd_data <= sram_dq;
        end

    assign sram_addr     = r_addr;
    assign sram_dq       = r_dq_oe ? r_wdata : {DATA_W{1'bz}};
    assign sram_ce_n     = r_ce_n;
    assign sram_oe_n     = r_oe_n;
    assign sram_we_n     = r_we_n;
    assign bus.req_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.wdata_ack = r_wdata_ack;
    assign bus.wr_done   = r_wr_done;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_last   = r_rd_last;
endmodule
